// File: rtl/rr_arb2_2bit_pkg.sv
// rr_arb2_2bit_pkg: default widths and the source-tag type for the round-robin arbiter
`include "rr_arb_defs.vh"
package rr_arb2_2bit_pkg;
    localparam int DEF_DATA_W     = `RR_DATA_W;
    localparam int DEF_CNT_W      = `RR_CNT_W;
    localparam int DEF_FIFO_DEPTH = 2;
    typedef enum logic {
        SRC_IN1 = `RR_SRC_IN1,
        SRC_IN2 = `RR_SRC_IN2
    } src_e;
endpackage

// File: rtl/fifo_sync_2entry.sv
// fifo_sync_2entry: two-entry FIFO with registered storage and a combinational head
module fifo_sync_2entry #(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d, rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;
    assign full    = cnt_q == 2'(DEPTH);
    assign empty   = cnt_q == 2'd0;
    assign head    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_comb begin
        mem_d       = mem_q;
        mem_d[wr_q] = do_push ? din : mem_q[wr_q];
        wr_d        = do_push ? !wr_q : wr_q;
        rd_d        = do_pop ? !rd_q : rd_q;
        cnt_d       = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rr_arb_defs.vh
// rr_arb_defs: shared widths and source-tag encodings for the round-robin arbiter slice
`ifndef RR_ARB_DEFS_VH
`define RR_ARB_DEFS_VH
`define RR_DATA_W 2
`define RR_SRC_IN1 1'b0
`define RR_SRC_IN2 1'b1
`define RR_CNT_W 8
`endif

// File: rtl/rr_arb2_2bit.sv
// rr_arb2_2bit: two-source round-robin arbiter feeding a 2-entry tagged output FIFO,
// with per-source saturating grant counters for debug.
module rr_arb2_2bit
    import rr_arb2_2bit_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    input  logic              in2_valid,
    input  logic [DATA_W-1:0] in2_data,
    output logic              in2_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  grant_cnt2
);
    src_e             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic             win2, full, empty, acc1, acc2;
    logic [DATA_W:0]  din, head;
    // in1 is the default winner; in2 wins only when it alone is valid or holds priority
    assign win2      = in2_valid && (!in1_valid || ptr_q == SRC_IN2);
    assign in1_ready = !full && !win2;
    assign in2_ready = !full && win2;
    assign acc1      = in1_valid && in1_ready;
    assign acc2      = in2_valid && in2_ready;
    assign din       = {win2, win2 ? in2_data : in1_data};
    assign out_valid = !empty;
    assign out_src   = head[DATA_W];
    assign out_data  = head[DATA_W-1:0];
    assign grant_cnt1 = cnt1_q;
    assign grant_cnt2 = cnt2_q;
    always_comb begin
        ptr_d  = acc1 ? SRC_IN2 : acc2 ? SRC_IN1 : ptr_q;
        cnt1_d = clr_cnt ? '0 : (acc1 && !(&cnt1_q)) ? cnt1_q + 1'b1 : cnt1_q;
        cnt2_d = clr_cnt ? '0 : (acc2 && !(&cnt2_q)) ? cnt2_q + 1'b1 : cnt2_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= SRC_IN1;
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end
    fifo_sync_2entry #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (acc1 || acc2),
        .pop   (out_valid && out_ready),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: doc/rr_arb2_2bit.md
Name: rr_arb2_2bit

Overview:
- Two-source, 2-bit-wide round-robin arbiter with valid/ready handshakes on both inputs and on the output.
- Sits directly upstream of the 2:1 2-bit multiplexer stage.
- Chooses which source drives the data path each cycle, muxes the winning 2-bit word, and buffers it in a small output FIFO.
- Tags each word with its source and keeps per-source saturating grant counters for debug.

Parameters:
- DATA_W, 2: payload width of each input and of the output.
- FIFO_DEPTH, 2: output buffer entries; fixed at 2 for this release.
- CNT_W, 8: width of each grant counter.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in1_valid  in  1  source 1 has a word.
- in1_data  in  DATA_W  source 1 payload.
- in1_ready  out  1  source 1 word accepted this cycle when high with in1_valid.
- in2_valid  in  1  source 2 has a word.
- in2_data  in  DATA_W  source 2 payload.
- in2_ready  out  1  source 2 word accepted this cycle when high with in2_valid.
- out_valid  out  1  head of FIFO valid.
- out_data  out  DATA_W  head payload.
- out_src  out  1  head source tag: 0 = in1, 1 = in2.
- out_ready  in  1  consumer accepts the head.
- clr_cnt  in  1  synchronous clear of both counters.
- grant_cnt1  out  CNT_W  accepted words from in1.
- grant_cnt2  out  CNT_W  accepted words from in2.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_src=0, grant_cnt1=0, grant_cnt2=0, FIFO empty, priority pointer set to in1.
- Ready signals are combinational from state and the valids. After reset, in1_ready=1 (priority in1, not full) and in2_ready=0, unless only in2_valid=1.
- Grant (combinational):
  - Only in1_valid high: in1 wins.
  - Only in2_valid high: in2 wins.
  - Both high: the source named by the priority pointer wins.
  - Neither high: no grant.
- Readiness: inX_ready = grantX && !full. At most one input is accepted per cycle. The losing source sees ready=0.
- Full rule: ready ignores a simultaneous pop. At count==FIFO_DEPTH, no push occurs even if out_ready=1 that cycle.
- Pointer: updated only on an accepted word, and moves to the other source. A grant to in1 makes in2 the priority, and vice versa. No accept means the pointer holds.
- FIFO:
  - Push = any inX_valid && inX_ready; it stores {src, data}.
  - Pop = out_valid && out_ready.
  - Push and pop in the same cycle at count 1: count stays 1, new word becomes the head next cycle.
  - Pop when empty is impossible (out_valid=0).
- Latency: a word accepted at edge N appears on out_valid/out_data/out_src after edge N (1 cycle) if the FIFO was empty.
- Output stability: out_data/out_src hold stable while out_valid && !out_ready.
- Ordering: words leave in acceptance order.
- Counters:
  - grantX_cnt increments on each accept from source X.
  - Saturates at 2^CNT_W-1 (255) with no wrap.
  - clr_cnt=1 zeroes both counters next edge and has precedence over a same-cycle increment.
- Reset mid-operation: asynchronous. Buffered words are discarded, the pointer returns to in1, and counters zero immediately, independent of clk.
- Inputs X/Z on valid are not tolerated: the bench treats out_valid going X as a failure.

Decomposition:
- Shared header rr_arb_defs.vh, guarded with `ifndef, holding:
  - `define RR_DATA_W 2
  - `define RR_SRC_IN1 1'b0
  - `define RR_SRC_IN2 1'b1
  - `define RR_CNT_W 8
- One sub-module, fifo_sync_2entry: width-parameterised, 2-deep, push/pop/full/empty/head, async active-high reset.
- Arbiter, pointer, mux and counters stay in the top-level rr_arb2_2bit.

Test Plan:
- Single source: reset, then in1_valid=1 with data 2'b10 for 1 cycle, out_ready=1 -> in1_ready=1; next cycle out_valid=1, out_data=2'b10, out_src=0; grant_cnt1=1.
- Contention: both valid continuously, in1=2'b01, in2=2'b11, out_ready=1 -> accepted sequence in1,in2,in1,in2; out_src toggles 0,1,0,1; counters equal after 8 cycles (4/4).
- Backpressure: out_ready=0, in1_valid held high -> two words accepted, then in1_ready=0 (full); out_data holds the first word stable. Raising out_ready=1 for 1 cycle -> one pop, and no push that cycle.
- Push/pop at count 1: count 1, out_ready=1, in2 pushes 2'b00 -> next cycle out_valid=1, head=2'b00, src=1.
- Counter saturation and clear: 300 in1 accepts -> grant_cnt1=255. Assert clr_cnt in the same cycle as an accept -> grant_cnt1=0 next edge.
- Reset mid-stream: FIFO holding 2 words, assert reset between clock edges -> out_valid=0 immediately; after release with both valid, in1 is granted first.
